// File: rtl/led_flash_multi.sv
// Multi-pattern LED flasher. It runs a counted flash sequence under a
// start/busy/done handshake and can be aborted. LEDs are active-low, so 1 means off.
module led_flash_multi #(
  parameter int unsigned LED_W      = 4,
  parameter int unsigned PERIOD_CYC = 10_000_000,
  parameter int unsigned CNT_W      = 24,
  parameter int unsigned TIMES_W    = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         mode,
  input  logic [TIMES_W-1:0] times,
  output logic               busy,
  output logic               flash_done,
  output logic [LED_W-1:0]   led
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [CNT_W-1:0] TimerMax = CNT_W'(PERIOD_CYC - 1);

  state_e             state_q, state_d;
  logic [LED_W-1:0]   led_q, led_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic [TIMES_W:0]   step_q, step_d;
  logic [1:0]         mode_q, mode_d;
  logic [TIMES_W-1:0] times_q, times_d;

  logic               tick;
  logic               last_step;
  logic [TIMES_W:0]   step_inc;
  logic [LED_W-1:0]   init_pat;
  logic [LED_W-1:0]   next_pat;

  assign tick      = (timer_q == TimerMax);
  assign step_inc  = step_q + 1'b1;
  // Both sides are TIMES_W+1 bits wide, so 2*times cannot overflow.
  assign last_step = (step_inc == {times_q, 1'b0});

  // Initial pattern loaded at an accepted start. It uses the live mode input.
  always_comb begin
    init_pat = '1;
    if (mode == 2'd2) begin
      for (int i = 0; i < int'(LED_W); i++) begin
        init_pat[i] = i[0];
      end
    end else if (mode == 2'd3) begin
      init_pat[0] = 1'b0;
    end
  end

  // Pattern advance applied on each tick. It uses the latched mode.
  always_comb begin
    next_pat = led_q;
    unique case (mode_q)
      2'd0:    next_pat = {led_q[LED_W-1:1], ~led_q[0]};
      2'd1:    next_pat = ~led_q;
      2'd2:    next_pat = ~led_q;
      default: next_pat = {led_q[LED_W-2:0], led_q[LED_W-1]};
    endcase
  end

  // Next-state logic for the sequencer, the timer, the step count and the LED register.
  always_comb begin
    state_d = state_q;
    led_d   = led_q;
    timer_d = timer_q;
    step_d  = step_q;
    mode_d  = mode_q;
    times_d = times_q;
    unique case (state_q)
      StIdle: begin
        led_d   = '1;
        timer_d = '0;
        step_d  = '0;
        if (start && !abort) begin
          mode_d  = mode;
          times_d = times;
          if (times == '0) begin
            state_d = StDone;
          end else begin
            state_d = StRun;
            led_d   = init_pat;
          end
        end
      end
      StRun: begin
        if (abort) begin
          // Abort wins over a coincident final tick, so no done pulse is produced.
          state_d = StIdle;
          led_d   = '1;
          timer_d = '0;
          step_d  = '0;
        end else if (tick) begin
          timer_d = '0;
          if (last_step) begin
            state_d = StDone;
            led_d   = '1;
            step_d  = '0;
          end else begin
            step_d = step_inc;
            led_d  = next_pat;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
        led_d   = '1;
      end
      default: begin
        state_d = StIdle;
        led_d   = '1;
      end
    endcase
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      led_q   <= '1;
      timer_q <= '0;
      step_q  <= '0;
      mode_q  <= '0;
      times_q <= '0;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      timer_q <= timer_d;
      step_q  <= step_d;
      mode_q  <= mode_d;
      times_q <= times_d;
    end
  end

  // Outputs decode from the state, so reset clears them immediately.
  always_comb begin
    busy       = (state_q == StRun);
    flash_done = (state_q == StDone);
    led        = led_q;
  end

endmodule
